// File: rtl/stream_arb_pkg.sv
// Shared defaults, FSM state type and id-width helper for the QoS stream arbiter.
package stream_arb_pkg;

  localparam int unsigned T_DATA_WIDTH_DEF = 8;
  localparam int unsigned T_QOS_WIDTH_DEF  = 4;
  localparam int unsigned STREAM_CNT_DEF   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Width of a stream index; never below one bit.
  function automatic int unsigned id_w(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = int'($clog2(n));
    return w;
  endfunction

endpackage

// File: rtl/qos_rr_picker.sv
// Combinational winner pick: highest nonzero QoS or QoS 0, first in round-robin order after last_gnt.
module qos_rr_picker
  import stream_arb_pkg::*;
#(
  parameter int unsigned STREAM_COUNT = STREAM_CNT_DEF,
  parameter int unsigned T_QOS__WIDTH = T_QOS_WIDTH_DEF,
  localparam int unsigned ID_W = id_w(STREAM_COUNT)
) (
  input  logic [STREAM_COUNT-1:0]                   valid_i,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] qos_i,
  input  logic [ID_W-1:0]                           last_gnt_i,
  output logic [ID_W-1:0]                           win_o,
  output logic                                      any_valid_o
);

  logic [T_QOS__WIDTH-1:0] max_qos;
  logic [ID_W-1:0]         idx;
  logic                    found;

  // QoS 0 ties with the maximum, so the first stream in RR order matching either wins.
  always_comb begin
    max_qos = '0;
    for (int unsigned k = 0; k < STREAM_COUNT; k++) begin
      if (valid_i[k] && (qos_i[k] > max_qos)) max_qos = qos_i[k];
    end
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      idx = ID_W'((32'(last_gnt_i) + 32'd1 + i) % STREAM_COUNT);
      if (!found && valid_i[idx] && ((qos_i[idx] == '0) || (qos_i[idx] == max_qos))) begin
        found = 1'b1;
        win_o = idx;
      end
    end
  end

  assign any_valid_o = |valid_i;

endmodule

// File: rtl/qos_stream_arbiter.sv
// Packet-level N:1 stream arbiter; a granted stream owns the output until its last beat or it drops valid.
module qos_stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = T_DATA_WIDTH_DEF,
  parameter int unsigned T_QOS__WIDTH = T_QOS_WIDTH_DEF,
  parameter int unsigned STREAM_COUNT = STREAM_CNT_DEF,
  localparam int unsigned ID_W = id_w(STREAM_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [STREAM_COUNT-1:0]                   s_last_i,
  input  logic [STREAM_COUNT-1:0]                   s_valid_i,
  output logic [STREAM_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_QOS__WIDTH-1:0]                   m_qos_o,
  output logic [ID_W-1:0]                           m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_gnt_q, last_gnt_d;
  logic [ID_W-1:0]  win;
  logic             any_valid;
  logic [ID_W-1:0]  sel;
  logic [STREAM_COUNT-1:0] sel_oh;

  qos_rr_picker #(
    .STREAM_COUNT (STREAM_COUNT),
    .T_QOS__WIDTH (T_QOS__WIDTH)
  ) u_picker (
    .valid_i     (s_valid_i),
    .qos_i       (s_qos_i),
    .last_gnt_i  (last_gnt_q),
    .win_o       (win),
    .any_valid_o (any_valid)
  );

  always_comb begin
    sel = (state_q == ST_BUSY) ? gnt_id_q : win;
    sel_oh = '0;
    sel_oh[sel] = 1'b1;
  end

  // Output muxing and next-state; m_ready_i low freezes state and pointer.
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_gnt_d = last_gnt_q;
    s_ready_o  = '0;
    m_valid_o  = 1'b0;
    m_data_o   = '0;
    m_qos_o    = '0;
    m_id_o     = '0;
    m_last_o   = 1'b0;
    if (!rst) begin
      if (state_q == ST_BUSY) begin
        m_valid_o = s_valid_i[gnt_id_q];
        m_data_o  = s_data_i[gnt_id_q];
        m_qos_o   = s_qos_i[gnt_id_q];
        m_last_o  = s_last_i[gnt_id_q];
        m_id_o    = gnt_id_q;
        s_ready_o = sel_oh & {STREAM_COUNT{m_ready_i}};
        if (m_ready_i && (!s_valid_i[gnt_id_q] || s_last_i[gnt_id_q])) state_d = ST_IDLE;
      end else if (any_valid) begin
        m_valid_o = 1'b1;
        m_data_o  = s_data_i[win];
        m_qos_o   = s_qos_i[win];
        m_last_o  = s_last_i[win];
        m_id_o    = win;
        s_ready_o = sel_oh & {STREAM_COUNT{m_ready_i}};
        if (m_ready_i) begin
          last_gnt_d = win;
          if (!s_last_i[win]) begin
            state_d  = ST_BUSY;
            gnt_id_d = win;
          end
        end
      end else begin
        s_ready_o = {STREAM_COUNT{m_ready_i}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= '0;
      last_gnt_q <= ID_W'(STREAM_COUNT - 1);
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_qos_stream_arbiter.sv
// Scoreboard bench for qos_stream_arbiter: expected beats queued at stimulus, compared on each output handshake.
interface stream_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned QW = 4,
  parameter int unsigned N  = 4
) (input logic clk);
  logic                  rst;
  logic [N-1:0][DW-1:0]  s_data_i;
  logic [N-1:0][QW-1:0]  s_qos_i;
  logic [N-1:0]          s_last_i;
  logic [N-1:0]          s_valid_i;
  logic [N-1:0]          s_ready_o;
  logic [DW-1:0]         m_data_o;
  logic [QW-1:0]         m_qos_o;
  logic [$clog2(N)-1:0]  m_id_o;
  logic                  m_last_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
endinterface

module tb_qos_stream_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned QW = 4;
  localparam int unsigned N  = 4;

  typedef struct {
    int id;
    int data;
    int qos;
    int last;
  } beat_t;

  logic  clk = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  always #5 clk = ~clk;

  stream_if #(.DW(DW), .QW(QW), .N(N)) sif (.clk(clk));

  qos_stream_arbiter #(
    .T_DATA_WIDTH (DW),
    .T_QOS__WIDTH (QW),
    .STREAM_COUNT (N)
  ) dut (
    .clk       (clk),
    .rst       (sif.rst),
    .s_data_i  (sif.s_data_i),
    .s_qos_i   (sif.s_qos_i),
    .s_last_i  (sif.s_last_i),
    .s_valid_i (sif.s_valid_i),
    .s_ready_o (sif.s_ready_o),
    .m_data_o  (sif.m_data_o),
    .m_qos_o   (sif.m_qos_o),
    .m_id_o    (sif.m_id_o),
    .m_last_o  (sif.m_last_o),
    .m_valid_o (sif.m_valid_o),
    .m_ready_i (sif.m_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input int k, input logic v, input logic [QW-1:0] q,
                       input logic [DW-1:0] d, input logic l);
    sif.s_valid_i[k] = v;
    sif.s_qos_i[k]   = q;
    sif.s_data_i[k]  = d;
    sif.s_last_i[k]  = l;
  endtask

  task automatic clear_all();
    for (int k = 0; k < int'(N); k++) set_s(k, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic push(input int id, input int data, input int qos, input int last);
    beat_t b;
    b.id = id; b.data = data; b.qos = qos; b.last = last;
    exp_q.push_back(b);
  endtask

  // Every accepted output beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!sif.rst && sif.m_valid_o && sif.m_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(sif.m_id_o), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_id",   32'(sif.m_id_o),   32'(mon_e.id));
        chk("sb_data", 32'(sif.m_data_o), 32'(mon_e.data));
        chk("sb_qos",  32'(sif.m_qos_o),  32'(mon_e.qos));
        chk("sb_last", 32'(sif.m_last_o), 32'(mon_e.last));
      end
    end
  end

  initial begin
    int beat;
    logic stall;

    sif.rst = 1'b1;
    sif.m_ready_i = 1'b1;
    clear_all();
    set_s(0, 1'b1, 4'd1, 8'hA0, 1'b1);
    set_s(1, 1'b1, 4'd2, 8'hA1, 1'b1);
    @(negedge clk);
    chk("rst_s_ready", 32'(sif.s_ready_o), 32'h0);
    chk("rst_m_valid", 32'(sif.m_valid_o), 32'h0);
    chk("rst_m_data",  32'(sif.m_data_o),  32'h0);
    step();
    sif.rst = 1'b0;
    clear_all();

    // Idle, nothing valid
    @(negedge clk);
    chk("idle_s_ready", 32'(sif.s_ready_o), 32'hF);
    chk("idle_m_valid", 32'(sif.m_valid_o), 32'h0);
    chk("idle_m_id",    32'(sif.m_id_o),    32'h0);
    step();
    sif.m_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_nrdy_s_ready", 32'(sif.s_ready_o), 32'h0);
    step();
    sif.m_ready_i = 1'b1;

    // Higher QoS wins, zero-latency mux
    set_s(1, 1'b1, 4'd3, 8'h11, 1'b1);
    set_s(2, 1'b1, 4'd9, 8'h22, 1'b1);
    push(2, 'h22, 9, 1);
    @(negedge clk);
    chk("qos_m_id",    32'(sif.m_id_o),    32'd2);
    chk("qos_s_ready", 32'(sif.s_ready_o), 32'b0100);
    chk("qos_m_data",  32'(sif.m_data_o),  32'h22);
    step();
    set_s(2, 1'b0, '0, '0, 1'b0);
    push(1, 'h11, 3, 1);
    @(negedge clk);
    chk("qos_next_id", 32'(sif.m_id_o), 32'd1);
    step();
    clear_all();

    // 5-beat packet on stream 2 holds grant against qos 15 on stream 3, with one stall
    beat = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      stall = (cyc == 3);
      sif.m_ready_i = !stall;
      set_s(2, 1'b1, 4'd9, 8'(8'h30 + beat), beat == 4);
      if (cyc >= 2) set_s(3, 1'b1, 4'd15, 8'h3F, 1'b1);
      if (!stall) push(2, 'h30 + beat, 9, (beat == 4) ? 1 : 0);
      @(negedge clk);
      chk("pkt_m_id",   32'(sif.m_id_o),    32'd2);
      chk("pkt_m_data", 32'(sif.m_data_o),  32'('h30 + beat));
      chk("pkt_s_ready", 32'(sif.s_ready_o), stall ? 32'h0 : 32'b0100);
      step();
      if (!stall) beat++;
    end
    sif.m_ready_i = 1'b1;
    set_s(2, 1'b0, '0, '0, 1'b0);
    push(3, 'h3F, 15, 1);
    @(negedge clk);
    chk("pkt_after_id", 32'(sif.m_id_o), 32'd3);
    step();
    clear_all();

    // Equal QoS, continuous single-beat traffic rotates 0,1,2,3,0
    for (int k = 0; k < int'(N); k++) set_s(k, 1'b1, 4'd5, 8'(8'h40 + k), 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(i % 4, 'h40 + (i % 4), 5, 1);
      @(negedge clk);
      chk("rr_m_id", 32'(sif.m_id_o), 32'(i % 4));
      step();
    end
    clear_all();

    // QoS 0 ties with the highest QoS; RR order decides
    set_s(1, 1'b1, 4'd0,  8'h51, 1'b1);
    set_s(3, 1'b1, 4'd12, 8'h53, 1'b1);
    push(1, 'h51, 0, 1);
    @(negedge clk);
    chk("zq_lg0_win", 32'(sif.m_id_o), 32'd1);
    step();
    push(3, 'h53, 12, 1);
    @(negedge clk);
    chk("zq_lg1_win", 32'(sif.m_id_o), 32'd3);
    step();
    clear_all();

    // Granted stream drops valid mid-packet: abort, then re-arbitrate
    set_s(0, 1'b1, 4'd2, 8'h60, 1'b0);
    push(0, 'h60, 2, 0);
    @(negedge clk);
    chk("ab_first_id", 32'(sif.m_id_o), 32'd0);
    step();
    set_s(0, 1'b1, 4'd2, 8'h61, 1'b0);
    push(0, 'h61, 2, 0);
    step();
    set_s(0, 1'b0, 4'd2, 8'h62, 1'b0);
    set_s(1, 1'b1, 4'd7, 8'h71, 1'b1);
    @(negedge clk);
    chk("ab_m_valid", 32'(sif.m_valid_o), 32'h0);
    chk("ab_s_ready", 32'(sif.s_ready_o), 32'b0001);
    step();
    push(1, 'h71, 7, 1);
    @(negedge clk);
    chk("ab_rearb_id",    32'(sif.m_id_o),    32'd1);
    chk("ab_rearb_valid", 32'(sif.m_valid_o), 32'h1);
    step();
    clear_all();

    step();
    step();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
